// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle carrying a clearable control field and a
// datapath field between pipeline stages.
interface pipe_stage_skid_if #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 64
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and flush. SKID=1 adds a
// second entry so in_ready is a flop; SKID=0 is a single register.
//
//   state | meaning (SKID=1, occupancy_o = state)
//   EMPTY | nothing held, ready to accept
//   BUSY  | head valid in main register, skid free
//   FULL  | main and skid both valid, input blocked
module pipe_stage_skid #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 16,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    pipe_stage_skid_if.slave  in_i,
    pipe_stage_skid_if.master out_o,
    output logic [1:0]        occupancy_o
);

    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DATA_W-1:0] main_data_q;
    logic              head_valid;

    if (SKID) begin : g_skid
        typedef enum logic [1:0] {
            EMPTY = 2'd0,
            BUSY  = 2'd1,
            FULL  = 2'd2
        } state_e;

        state_e            state_q;
        logic              ready_q;
        logic [CTRL_W-1:0] skid_ctrl_q;
        logic [DATA_W-1:0] skid_data_q;
        logic              in_fire;
        logic              out_fire;

        assign in_fire  = in_i.valid & ready_q;
        assign out_fire = head_valid & out_o.ready;

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                state_q     <= EMPTY;
                ready_q     <= 1'b1;
                main_ctrl_q <= '0;
                main_data_q <= '0;
                skid_ctrl_q <= '0;
                skid_data_q <= '0;
            end else if (flush_i) begin
                // data registers keep their value; only ctrl must be scrubbed
                state_q     <= EMPTY;
                ready_q     <= 1'b1;
                main_ctrl_q <= '0;
                skid_ctrl_q <= '0;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (in_fire) begin
                            state_q     <= BUSY;
                            main_ctrl_q <= in_i.ctrl;
                            main_data_q <= in_i.data;
                        end
                    end
                    BUSY: begin
                        if (in_fire && out_fire) begin
                            main_ctrl_q <= in_i.ctrl;
                            main_data_q <= in_i.data;
                        end else if (in_fire) begin
                            state_q     <= FULL;
                            ready_q     <= 1'b0;
                            skid_ctrl_q <= in_i.ctrl;
                            skid_data_q <= in_i.data;
                        end else if (out_fire) begin
                            state_q <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (out_fire) begin
                            state_q     <= BUSY;
                            ready_q     <= 1'b1;
                            main_ctrl_q <= skid_ctrl_q;
                            main_data_q <= skid_data_q;
                        end
                    end
                    default: begin
                        state_q <= EMPTY;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end

        assign head_valid  = (state_q != EMPTY);
        assign in_i.ready  = ready_q;
        assign occupancy_o = state_q;
    end else begin : g_single
        logic valid_q;
        logic in_ready;
        logic in_fire;
        logic out_fire;

        assign in_ready = !valid_q | out_o.ready;
        assign in_fire  = in_i.valid & in_ready;
        assign out_fire = valid_q & out_o.ready;

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                valid_q     <= 1'b0;
                main_ctrl_q <= '0;
                main_data_q <= '0;
            end else if (flush_i) begin
                valid_q     <= 1'b0;
                main_ctrl_q <= '0;
            end else if (in_fire) begin
                valid_q     <= 1'b1;
                main_ctrl_q <= in_i.ctrl;
                main_data_q <= in_i.data;
            end else if (out_fire) begin
                valid_q <= 1'b0;
            end
        end

        assign head_valid  = valid_q;
        assign in_i.ready  = in_ready;
        assign occupancy_o = {1'b0, valid_q};
    end

    // a bubble must never carry reg_write/mem_write downstream
    assign out_o.valid = head_valid;
    assign out_o.ctrl  = head_valid ? main_ctrl_q : '0;
    assign out_o.data  = main_data_q;

endmodule
